// File: rtl/vga_reg_scanner_pkg.sv
// Shared definitions for the register-window scanner, font mux and text renderer:
// FSM encoding, default scan window geometry and the substitute character for unanswered positions.
package vga_reg_scanner_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SAMPLE = 3'd2,
    S_WRITE  = 3'd3,
    S_PARK   = 3'd4,
    S_DONE   = 3'd5
  } scan_state_t;

  localparam int DEF_COLS      = 80;
  localparam int DEF_ROW_FIRST = 3;
  localparam int DEF_ROW_LAST  = 33;
  localparam int DEF_COL_FIRST = 10;
  localparam int DEF_COL_LAST  = 17;

  localparam logic [7:0] PLACEHOLDER_CHAR = 8'h3F;

endpackage

// File: rtl/vga_reg_scanner_if.sv
// Text-RAM write port: the scanner holds we/addr/data until the RAM raises ready.
interface vga_reg_scanner_if;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_ready;

  modport master (output ram_we, ram_addr, ram_data, input ram_ready);
  modport slave  (input ram_we, ram_addr, ram_data, output ram_ready);
endinterface

// File: rtl/vga_reg_scanner.sv
// Walks a rectangular window of the register display, asks the font mux for each
// character and copies it into text RAM, one position at a time.
module vga_reg_scanner
  import vga_reg_scanner_pkg::*;
#(
  parameter int COLS       = DEF_COLS,
  parameter int ROW_FIRST  = DEF_ROW_FIRST,
  parameter int ROW_LAST   = DEF_ROW_LAST,
  parameter int COL_FIRST  = DEF_COL_FIRST,
  parameter int COL_LAST   = DEF_COL_LAST,
  parameter int SAMPLE_TMO = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      auto,
  output logic [7:0]                col,
  output logic [7:0]                row,
  input  logic [7:0]                char_in,
  input  logic                      char_valid,
  output logic                      busy,
  output logic                      done,
  vga_reg_scanner_if.master         ram
);

  localparam int TMO_W = (SAMPLE_TMO > 1) ? $clog2(SAMPLE_TMO) : 1;
  localparam logic [11:0]      ADDR_FIRST = 12'(ROW_FIRST * COLS + COL_FIRST);
  // Row wrap jumps from COL_LAST of one row to COL_FIRST of the next.
  localparam logic [11:0]      ROW_STEP   = 12'(COLS - (COL_LAST - COL_FIRST));
  localparam logic [7:0]       ROW_F      = 8'(ROW_FIRST);
  localparam logic [7:0]       ROW_L      = 8'(ROW_LAST);
  localparam logic [7:0]       COL_F      = 8'(COL_FIRST);
  localparam logic [7:0]       COL_L      = 8'(COL_LAST);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(SAMPLE_TMO - 1);

  scan_state_t      state_reg, state_next;
  logic [7:0]       row_reg, row_next;
  logic [7:0]       col_reg, col_next;
  logic [11:0]      addr_reg, addr_next;
  logic [7:0]       data_reg, data_next;
  logic [TMO_W-1:0] tmo_reg, tmo_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      row_reg   <= '0;
      col_reg   <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      tmo_reg   <= '0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      tmo_reg   <= tmo_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    row_next     = row_reg;
    col_next     = col_reg;
    addr_next    = addr_reg;
    data_next    = data_reg;
    tmo_next     = tmo_reg;
    col          = '0;
    row          = '0;
    ram.ram_we   = 1'b0;
    ram.ram_addr = addr_reg;
    ram.ram_data = data_reg;
    busy         = (state_reg != S_IDLE);
    done         = (state_reg == S_DONE);

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          row_next   = ROW_F;
          col_next   = COL_F;
          addr_next  = ADDR_FIRST;
          state_next = S_DRIVE;
        end
      end
      S_DRIVE: begin
        col        = col_reg;
        row        = row_reg;
        tmo_next   = '0;
        state_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        col = col_reg;
        row = row_reg;
        if (char_valid) begin
          data_next  = char_in;
          tmo_next   = '0;
          state_next = S_WRITE;
        end else if (tmo_reg == TMO_LAST) begin
          data_next  = PLACEHOLDER_CHAR;
          tmo_next   = '0;
          state_next = S_WRITE;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
      end
      S_WRITE: begin
        ram.ram_we = 1'b1;
        if (ram.ram_ready) state_next = S_PARK;
      end
      S_PARK: begin
        // col/row stay at zero here so the mux sees a fresh select next DRIVE.
        if (row_reg == ROW_L && col_reg == COL_L) begin
          state_next = S_DONE;
        end else if (col_reg == COL_L) begin
          col_next   = COL_F;
          row_next   = row_reg + 8'd1;
          addr_next  = addr_reg + ROW_STEP;
          state_next = S_DRIVE;
        end else begin
          col_next   = col_reg + 8'd1;
          addr_next  = addr_reg + 12'd1;
          state_next = S_DRIVE;
        end
      end
      S_DONE: begin
        if (auto) begin
          row_next   = ROW_F;
          col_next   = COL_F;
          addr_next  = ADDR_FIRST;
          state_next = S_DRIVE;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vga_reg_scanner.sv
// Scoreboard bench: stimulus pushes expected RAM writes, a negedge monitor pops and
// compares each accepted write and checks the PARK gap after it.
module tb_vga_reg_scanner;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       auto = 1'b0;
  logic [7:0] col, row;
  logic [7:0] char_in;
  logic       char_valid;
  logic       busy, done;
  logic       skip_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int stall_left = 0;
  logic [11:0] stall_addr = '0;
  int hold_251 = 0;
  wr_t exp_q[$];

  vga_reg_scanner_if ram_if ();

  vga_reg_scanner dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .auto       (auto),
    .col        (col),
    .row        (row),
    .char_in    (char_in),
    .char_valid (char_valid),
    .busy       (busy),
    .done       (done),
    .ram        (ram_if.master)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] hexch(input logic [7:0] v);
    logic [3:0] n;
    n = v[3:0];
    return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h41 + 8'(n) - 8'd10);
  endfunction

  // Font-mux model: echoes a hex digit for any non-parked select.
  assign char_valid = !(row == 8'd0 && col == 8'd0) && !(skip_en && row == 8'd5 && col == 8'd12);
  assign char_in    = hexch(row + col);

  initial ram_if.ram_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    if (stall_left > 0 && ram_if.ram_we && ram_if.ram_addr == stall_addr) begin
      ram_if.ram_ready = 1'b0;
      stall_left--;
    end else begin
      ram_if.ram_ready = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  int park_st = 0;
  int we_run = 0;
  logic [11:0] prev_addr;
  logic [7:0]  prev_data;
  always @(negedge clk) begin
    wr_t e;
    if (rst) begin
      park_st = 0;
      we_run  = 0;
    end else begin
      if (park_st == 1) begin
        chk("park_zero", {23'd0, ram_if.ram_we, row, col}, 32'd0);
        park_st = 2;
      end else if (park_st == 2) begin
        if (done) chk("after_park_done", {16'd0, row, col}, 32'd0);
        else      chk("after_park_drive", {31'd0, (row != 8'd0 && col != 8'd0)}, 32'd1);
        park_st = 0;
      end
      if (ram_if.ram_we) begin
        if (we_run > 0) begin
          chk("hold_addr", {20'd0, ram_if.ram_addr}, {20'd0, prev_addr});
          chk("hold_data", {24'd0, ram_if.ram_data}, {24'd0, prev_data});
        end
        we_run++;
        prev_addr = ram_if.ram_addr;
        prev_data = ram_if.ram_data;
      end else begin
        we_run = 0;
      end
      if (ram_if.ram_we && ram_if.ram_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write",
                   ram_if.ram_addr, ram_if.ram_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", {20'd0, ram_if.ram_addr}, {20'd0, e.addr});
          chk("wr_data", {24'd0, ram_if.ram_data}, {24'd0, e.data});
        end
        if (ram_if.ram_addr == 12'd251) hold_251 = we_run;
        we_run  = 0;
        park_st = 1;
      end
    end
  end

  task automatic push_scan(input bit skip);
    wr_t e;
    for (int r = 3; r <= 33; r++) begin
      for (int c = 10; c <= 17; c++) begin
        e.addr = 12'(r * 80 + c);
        e.data = (skip && r == 5 && c == 12) ? 8'h3F : hexch(8'(r + c));
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles from the start-sampling edge (DRIVE = cycle 1) to the done pulse.
  task automatic wait_done(output int cyc);
    bit got;
    cyc = 0;
    got = 0;
    while (cyc < 3000 && !got) begin
      @(negedge clk);
      cyc++;
      if (done) got = 1;
    end
  endtask

  task automatic run_scan(input string name, input int exp_cyc);
    int cyc;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc);
    chk({name, "_done_cycle"}, cyc, exp_cyc);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
    @(negedge clk);
    chk({name, "_idle_after"}, {30'd0, busy, done}, 32'd0);
    tick();
  endtask

  initial begin
    int cyc;
    int guard;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_outputs", {3'd0, busy, done, ram_if.ram_we, ram_if.ram_addr, ram_if.ram_data},
        32'd0);
    chk("reset_rowcol", {16'd0, row, col}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Plain scan with an always-ready RAM.
    push_scan(0);
    run_scan("basic", 4 * 248 + 1);

    // RAM stalls five cycles on the second write.
    push_scan(0);
    stall_addr = 12'd251;
    stall_left = 5;
    run_scan("stall", 4 * 248 + 1 + 5);
    chk("stall_hold_cycles", hold_251, 6);

    // Mux never answers at (5,12): '?' is written after the sample timeout.
    skip_en = 1'b1;
    push_scan(1);
    run_scan("timeout", 4 * 248 + 1 + 3);
    skip_en = 1'b0;

    // Reset in the middle of the 100th write (row 15, col 13).
    push_scan(0);
    stall_addr = 12'd1213;
    stall_left = 1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (guard < 2000 && !(ram_if.ram_we && ram_if.ram_addr == 12'd1213)) begin
      @(negedge clk);
      guard++;
    end
    chk("reached_write_100", {31'd0, ram_if.ram_we}, 32'd1);
    chk("queue_before_reset", exp_q.size(), 248 - 99);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stall_left = 0;
    exp_q.delete();
    @(negedge clk);
    chk("midscan_reset_outputs",
        {3'd0, busy, done, ram_if.ram_we, ram_if.ram_addr, ram_if.ram_data}, 32'd0);
    chk("midscan_reset_rowcol", {16'd0, row, col}, 32'd0);
    tick();
    push_scan(0);
    run_scan("restart", 4 * 248 + 1);

    // Auto restart; a start pulse mid-scan must not add writes.
    push_scan(0);
    push_scan(0);
    auto = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc);
    chk("auto_first_done_cycle", cyc, 4 * 248 + 1);
    @(posedge clk);
    #1 auto = 1'b0;
    @(negedge clk);
    chk("auto_redrive_pos", {15'd0, busy, row, col}, {15'd0, 1'b1, 8'd3, 8'd10});
    repeat (50) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc);
    chk("auto_second_done_seen", {31'd0, done}, 32'd1);
    chk("auto_queue_empty", exp_q.size(), 0);
    repeat (10) tick();
    @(negedge clk);
    chk("auto_idle_after", {30'd0, busy, done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
